reg_file_sp: RTL and testbench

Parametrised general-purpose register file with an integrated, bounds-checked stack pointer. It sits in the decode stage and is the successor to the fixed 4×8 register file. It adds configurable width and depth, push and pop with overflow and underflow detection, sticky error flags, and optional write-to-read bypass for the pipeline.

---
 rtl/reg_file_pkg.sv | 16 +
 rtl/reg_file_sp_sp_unit.sv | 43 ++++
 rtl/reg_file_sp.sv | 86 ++++++++
 tb/tb_reg_file_sp.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and SP operation encoding for the register file with stack pointer.
package reg_file_pkg;

  localparam int              DATA_W_DEF   = 8;
  localparam int              NREG_DEF     = 4;
  localparam logic [7:0]      SP_TOP_DEF   = 8'hFF;
  localparam logic [7:0]      SP_LIMIT_DEF = 8'hF0;

  typedef enum logic [1:0] {
    SP_HOLD = 2'd0,
    SP_PUSH = 2'd1,
    SP_POP  = 2'd2,
    SP_LOAD = 2'd3
  } sp_op_e;

endpackage

// File: rtl/reg_file_sp_sp_unit.sv
// Stack pointer next-state logic: resolves push/pop/load and flags out-of-bounds requests.
module sp_unit
  import reg_file_pkg::*;
#(
  parameter int                 DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0]  SP_TOP   = {DATA_W{1'b1}},
  parameter logic [DATA_W-1:0]  SP_LIMIT = {{(DATA_W-4){1'b1}}, 4'b0000}
) (
  input  logic [DATA_W-1:0] sp_cur,
  input  logic              sp_inc,
  input  logic              sp_dec,
  input  logic              wr_sp,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] sp_nxt,
  output logic              ovf_p,
  output logic              unf_p
);

  sp_op_e op;

  // An explicit write to SP overrides any push/pop; opposing requests cancel.
  always_comb begin
    op = SP_HOLD;
    if (wr_sp)                op = SP_LOAD;
    else if (sp_dec && !sp_inc) op = SP_PUSH;
    else if (sp_inc && !sp_dec) op = SP_POP;
  end

  always_comb begin
    sp_nxt = sp_cur;
    ovf_p  = 1'b0;
    unf_p  = 1'b0;
    case (op)
      SP_LOAD: sp_nxt = wdata;
      SP_PUSH: if (sp_cur == SP_LIMIT) ovf_p = 1'b1;
               else sp_nxt = sp_cur - 1'b1;
      SP_POP:  if (sp_cur == SP_TOP) unf_p = 1'b1;
               else sp_nxt = sp_cur + 1'b1;
      default: sp_nxt = sp_cur;
    endcase
  end

endmodule

// File: rtl/reg_file_sp.sv
// Parametrised register file with bounds-checked stack pointer, sticky error flags
// and optional same-cycle write-to-read bypass.
module reg_file_sp
  import reg_file_pkg::*;
#(
  parameter int                 DATA_W   = DATA_W_DEF,
  parameter int                 NREG     = NREG_DEF,
  parameter int                 SP_IDX   = NREG - 1,
  parameter logic [DATA_W-1:0]  SP_TOP   = {DATA_W{1'b1}},
  parameter logic [DATA_W-1:0]  SP_LIMIT = {{(DATA_W-4){1'b1}}, 4'b0000},
  parameter bit                 BYPASS   = 1'b1,
  localparam int                ADDR_W   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wr_en,
  input  logic              sp_dec,
  input  logic              sp_inc,
  input  logic              err_clr,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] sp,
  output logic              sp_ovf,
  output logic              sp_unf
);

  logic [NREG-1:0][DATA_W-1:0] regs_q, regs_d;
  logic                        ovf_q, ovf_d, unf_q, unf_d;
  logic                        wr_sp, ovf_p, unf_p;
  logic [DATA_W-1:0]           sp_nxt;

  assign wr_sp = wr_en && (wa == ADDR_W'(SP_IDX));

  sp_unit #(
    .DATA_W  (DATA_W),
    .SP_TOP  (SP_TOP),
    .SP_LIMIT(SP_LIMIT)
  ) u_sp (
    .sp_cur (regs_q[SP_IDX]),
    .sp_inc (sp_inc),
    .sp_dec (sp_dec),
    .wr_sp  (wr_sp),
    .wdata  (wdata),
    .sp_nxt (sp_nxt),
    .ovf_p  (ovf_p),
    .unf_p  (unf_p)
  );

  // sp_unit already folds an SP-targeted write into sp_nxt, so SP is always taken from it.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wa] = wdata;
    regs_d[SP_IDX] = sp_nxt;
    ovf_d = (ovf_q & ~err_clr) | ovf_p;
    unf_d = (unf_q & ~err_clr) | unf_p;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      regs_q         <= '0;
      regs_q[SP_IDX] <= SP_TOP;
      ovf_q          <= 1'b0;
      unf_q          <= 1'b0;
    end else begin
      regs_q <= regs_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  always_comb begin
    rd1 = regs_q[ra];
    rd2 = regs_q[rb];
    if (BYPASS && wr_en && (wa == ra)) rd1 = wdata;
    if (BYPASS && wr_en && (wa == rb)) rd2 = wdata;
  end

  assign sp     = regs_q[SP_IDX];
  assign sp_ovf = ovf_q;
  assign sp_unf = unf_q;

endmodule

// File: tb/tb_reg_file_sp.sv
// Scoreboard bench for reg_file_sp: bypass and non-bypass instances share stimulus.
module tb_reg_file_sp;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ra, rb, wa;
  logic [7:0] wdata;
  logic       wr_en, sp_dec, sp_inc, err_clr;
  logic [7:0] rd1, rd2, sp, rd1_n, rd2_n, sp_n;
  logic       sp_ovf, sp_unf, ovf_n, unf_n;

  always #5 clk = ~clk;

  reg_file_sp #(.BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .ra(ra), .rb(rb), .wa(wa), .wdata(wdata),
    .wr_en(wr_en), .sp_dec(sp_dec), .sp_inc(sp_inc), .err_clr(err_clr),
    .rd1(rd1), .rd2(rd2), .sp(sp), .sp_ovf(sp_ovf), .sp_unf(sp_unf)
  );

  reg_file_sp #(.BYPASS(1'b0)) dut_n (
    .clk(clk), .rst(rst), .ra(ra), .rb(rb), .wa(wa), .wdata(wdata),
    .wr_en(wr_en), .sp_dec(sp_dec), .sp_inc(sp_inc), .err_clr(err_clr),
    .rd1(rd1_n), .rd2(rd2_n), .sp(sp_n), .sp_ovf(ovf_n), .sp_unf(unf_n)
  );

  typedef struct {
    string      name;
    logic [7:0] rd1, rd2, rd1n, sp;
    logic       ovf, unf;
  } exp_t;

  exp_t q[$];
  logic obs_vld = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string name, input string fld, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s got %02h expected %02h", name, fld, act, req);
    end
  endtask

  // Monitor: pops one expectation per observed cycle, mid-cycle.
  always @(negedge clk) begin
    if (obs_vld) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_underrun got 0 entries expected 1");
      end else begin
        exp_t e;
        e = q.pop_front();
        cmp(e.name, "rd1",   rd1,   e.rd1);
        cmp(e.name, "rd2",   rd2,   e.rd2);
        cmp(e.name, "rd1_n", rd1_n, e.rd1n);
        cmp(e.name, "sp",    sp,    e.sp);
        cmp(e.name, "sp_n",  sp_n,  e.sp);
        cmp(e.name, "ovf",   {7'd0, sp_ovf}, {7'd0, e.ovf});
        cmp(e.name, "unf",   {7'd0, sp_unf}, {7'd0, e.unf});
      end
    end
  end

  task automatic exp_push(input string n, input logic [7:0] r1, input logic [7:0] r2,
                          input logic [7:0] r1n, input logic [7:0] s, input logic o, input logic u);
    exp_t e;
    e.name = n; e.rd1 = r1; e.rd2 = r2; e.rd1n = r1n; e.sp = s; e.ovf = o; e.unf = u;
    q.push_back(e);
    obs_vld = 1'b1;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    obs_vld = 1'b0;
  endtask

  task automatic idle();
    wr_en = 0; sp_dec = 0; sp_inc = 0; err_clr = 0; wa = 0; wdata = 0;
  endtask

  initial begin
    rst = 0; ra = 0; rb = 0; idle();
    cyc(); cyc();
    rst = 1;

    // Reset defaults on every address
    for (int a = 0; a < 4; a++) begin
      ra = 2'(a); rb = 2'(3 - a);
      exp_push($sformatf("reset_a%0d", a), (a == 3) ? 8'hFF : 8'h00, (a == 0) ? 8'hFF : 8'h00,
               (a == 3) ? 8'hFF : 8'h00, 8'hFF, 0, 0);
      cyc();
    end

    // Write R1 with same-cycle read
    ra = 1; rb = 1; wr_en = 1; wa = 1; wdata = 8'hA5;
    exp_push("wr_bypass", 8'hA5, 8'hA5, 8'h00, 8'hFF, 0, 0);
    cyc();
    idle();
    exp_push("wr_next", 8'hA5, 8'hA5, 8'hA5, 8'hFF, 0, 0);
    cyc();

    // 15 pushes down to SP_LIMIT
    ra = 0; rb = 1; sp_dec = 1;
    for (int i = 0; i < 15; i++) begin
      exp_push($sformatf("push%0d", i), 8'h00, 8'hA5, 8'h00, 8'(8'hFF - i), 0, 0);
      cyc();
    end
    exp_push("push_at_limit", 8'h00, 8'hA5, 8'h00, 8'hF0, 0, 0);
    cyc();
    sp_dec = 0; err_clr = 1;
    exp_push("ovf_set", 8'h00, 8'hA5, 8'h00, 8'hF0, 1, 0);
    cyc();
    err_clr = 0;
    exp_push("ovf_cleared", 8'h00, 8'hA5, 8'h00, 8'hF0, 0, 0);
    cyc();

    // Set and clear in the same cycle: set wins
    sp_dec = 1; err_clr = 1;
    exp_push("clr_and_set", 8'h00, 8'hA5, 8'h00, 8'hF0, 0, 0);
    cyc();
    sp_dec = 0; err_clr = 0;
    exp_push("set_wins", 8'h00, 8'hA5, 8'h00, 8'hF0, 1, 0);
    cyc();
    err_clr = 1;
    cyc();
    err_clr = 0;

    // Pop back up to 0xF8
    sp_inc = 1;
    for (int i = 0; i < 8; i++) cyc();
    sp_dec = 1;
    exp_push("inc_dec_same", 8'h00, 8'hA5, 8'h00, 8'hF8, 0, 0);
    cyc();
    idle();
    exp_push("inc_dec_hold", 8'h00, 8'hA5, 8'h00, 8'hF8, 0, 0);
    cyc();

    // Explicit SP write beats a push
    ra = 3; wr_en = 1; wa = 3; wdata = 8'h80; sp_dec = 1;
    exp_push("sp_write_bp", 8'h80, 8'hA5, 8'hF8, 8'hF8, 0, 0);
    cyc();
    idle();
    exp_push("sp_write", 8'h80, 8'hA5, 8'h80, 8'h80, 0, 0);
    cyc();

    // Back to top, then pop underflows
    wr_en = 1; wa = 3; wdata = 8'hFF;
    cyc();
    idle(); sp_inc = 1;
    exp_push("pop_at_top", 8'hFF, 8'hA5, 8'hFF, 8'hFF, 0, 0);
    cyc();
    idle();
    exp_push("unf_set", 8'hFF, 8'hA5, 8'hFF, 8'hFF, 0, 1);
    cyc();

    // Reset dominates a write and a push
    wr_en = 1; wa = 2; wdata = 8'h11;
    cyc();
    rst = 0; ra = 2; wa = 2; wdata = 8'h33; sp_dec = 1;
    exp_push("rst_cycle", 8'h33, 8'hA5, 8'h11, 8'hFF, 0, 1);
    cyc();
    rst = 1; idle();
    exp_push("rst_after", 8'h00, 8'h00, 8'h00, 8'hFF, 0, 0);
    cyc();

    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
